uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 121 ++++++++++++
 tb/tb_uart_tx_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterized UART transmitter: start bit, DATA_BITS payload LSB first,
// optional even/odd parity, 1 or 2 stop bits. All outputs are registered.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            data_out <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // Baud counter free-runs inside a frame; every state entry lands on a wrap.
            if (state != IDLE)
                cnt <= bit_end ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= data_in;
                        par_bit  <= (PARITY == 2) ? ~(^data_in) : ^data_in;
                        state    <= START;
                        cnt      <= '0;
                        data_out <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        idx      <= '0;
                        data_out <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                state    <= PAR;
                                data_out <= par_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                data_out <= 1'b1;
                            end
                        end else begin
                            idx      <= idx + IW'(1);
                            shreg    <= shreg >> 1;
                            data_out <= shreg[1];
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        data_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            data_out <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    data_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four parameterizations checked cycle by cycle
// against a frame-level model built from the bit sequence of each frame.
module tb_uart_tx_param;

    localparam int P_DB   [4] = '{8, 8, 8, 7};
    localparam int P_CPB  [4] = '{16, 16, 16, 4};
    localparam int P_PAR  [4] = '{0, 1, 2, 0};
    localparam int P_STOP [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       start [4];
    logic [8:0] din   [4];
    logic       line  [4];
    logic       bsy   [4];
    logic       dn    [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .data_in(din[0][7:0]),
        .data_out(line[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .data_in(din[1][7:0]),
        .data_out(line[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .data_in(din[2][7:0]),
        .data_out(line[2]), .busy(bsy[2]), .done(dn[2]));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .data_in(din[3][6:0]),
        .data_out(line[3]), .busy(bsy[3]), .done(dn[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int flen(input int u);
        return (1 + P_DB[u] + ((P_PAR[u] != 0) ? 1 : 0) + P_STOP[u]) * P_CPB[u];
    endfunction

    // Expected {done, busy, line} k cycles after the first START cycle.
    function automatic logic [2:0] model(input int u, input logic [8:0] d, input int k);
        int         db  = P_DB[u];
        int         cpb = P_CPB[u];
        int         len = flen(u);
        int         b;
        logic [8:0] m;
        logic       ln;
        m = d & ((9'd1 << db) - 9'd1);
        if (k >= len) return {(k == len), 1'b0, 1'b1};
        b = k / cpb;
        if (b == 0)                              ln = 1'b0;
        else if (b <= db)                        ln = m[b-1];
        else if (P_PAR[u] != 0 && b == db + 1)   ln = (^m) ^ (P_PAR[u] == 2);
        else                                     ln = 1'b1;
        return {1'b0, 1'b1, ln};
    endfunction

    // pre: start already held through the preceding done cycle.
    // hold: keep start high so the next frame chains directly.
    task automatic run_frame(input int u, input logic [8:0] d, input bit pre, input bit hold,
                             input bit scr, input bit mid, input int abort_at, output int bcnt);
        int         len = flen(u);
        logic [2:0] e;
        bcnt = 0;
        din[u] = d;
        if (!pre) start[u] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start[u] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk($sformatf("u%0d_abort_line", u), line[u], 1);
                chk($sformatf("u%0d_abort_busy", u), bsy[u], 0);
                chk($sformatf("u%0d_abort_done", u), dn[u], 0);
                @(posedge clk); #1;
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); #1;
                    chk($sformatf("u%0d_postabort_done%0d", u, j), dn[u], 0);
                    chk($sformatf("u%0d_postabort_busy%0d", u, j), bsy[u], 0);
                end
                return;
            end
            e = model(u, d, k);
            chk($sformatf("u%0d_line_k%0d", u, k), line[u], e[0]);
            chk($sformatf("u%0d_busy_k%0d", u, k), bsy[u], e[1]);
            chk($sformatf("u%0d_done_k%0d", u, k), dn[u], e[2]);
            if (bsy[u]) bcnt++;
            if (scr) din[u] = 9'($urandom);
            if (mid && !hold) start[u] = (k == len / 2);
            if (k < len) begin
                @(posedge clk); #1;
            end
        end
        if (!hold) begin
            start[u] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("u%0d_idle_line", u), line[u], 1);
            chk($sformatf("u%0d_idle_busy", u), bsy[u], 0);
            chk($sformatf("u%0d_idle_done", u), dn[u], 0);
        end
    endtask

    initial begin
        int bc;
        int u;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            din[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_rst_line", i), line[i], 1);
            chk($sformatf("u%0d_rst_busy", i), bsy[i], 0);
            chk($sformatf("u%0d_rst_done", i), dn[i], 0);
        end

        // Start raised right after reset release must be taken on the first edge.
        @(negedge clk);
        rst = 1'b0;
        run_frame(3, 9'h055, 0, 0, 0, 0, -1, bc);
        chk("u3_len_7n2_cpb4", bc, 40);

        run_frame(0, 9'h04C, 0, 0, 0, 0, -1, bc);
        chk("u0_len_default", bc, 160);
        run_frame(1, 9'h04C, 0, 0, 0, 0, -1, bc);
        chk("u1_len_even", bc, 176);
        run_frame(2, 9'h04C, 0, 0, 0, 0, -1, bc);
        chk("u2_len_odd", bc, 176);

        // Back-to-back with start held high the whole time.
        run_frame(0, 9'h0A5, 0, 1, 0, 0, -1, bc);
        chk("u0_b2b_len1", bc, 160);
        run_frame(0, 9'h03C, 1, 0, 0, 0, -1, bc);
        chk("u0_b2b_len2", bc, 160);

        // Mid-frame start pulse plus data_in scrambled every cycle.
        run_frame(0, 9'h0E1, 0, 0, 1, 1, -1, bc);
        chk("u0_mid_scr_len", bc, 160);

        run_frame(0, 9'h04C, 0, 0, 0, 0, 50, bc);
        run_frame(0, 9'h04C, 0, 0, 0, 0, -1, bc);
        chk("u0_len_after_abort", bc, 160);

        for (int i = 0; i < 14; i++) begin
            u = $urandom_range(0, 3);
            run_frame(u, 9'($urandom), 0, 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, -1, bc);
            chk($sformatf("u%0d_rand_len%0d", u, i), bc, flen(u));
        end
        for (int i = 0; i < 3; i++) begin
            run_frame(3, 9'($urandom), i != 0, i != 2, 1, 0, -1, bc);
            chk($sformatf("u3_chain_len%0d", i), bc, 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
